// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a bounded hold time and
// a mandatory one-cycle turnaround slot between consecutive owners.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       expired
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_id, w_id_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [7:0] r_hold, w_hold_nxt;
    logic       r_exp, w_exp_nxt;
    logic [1:0] w_win, w_idx;
    logic       w_found, w_limit, w_release;

    // First set request bit scanning cyclically upward from the pointer.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_limit   = (MAX_HOLD != 0) && (r_hold == 8'(MAX_HOLD));
    assign w_release = !req[r_id] || w_limit;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_id_nxt    = r_id;
        w_gnt_nxt   = r_gnt;
        w_hold_nxt  = r_hold;
        w_exp_nxt   = 1'b0;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_state_nxt = OWN;
                w_gnt_nxt   = 4'b0001 << w_win;
                w_id_nxt    = w_win;
                w_hold_nxt  = 8'd1;
            end
        end else if (w_release) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'b0000;
            w_id_nxt    = 2'b00;
            w_ptr_nxt   = r_id + 2'd1;
            w_hold_nxt  = 8'd0;
            // A limit hit coinciding with the owner's own drop is voluntary.
            w_exp_nxt   = req[r_id];
        end else begin
            w_hold_nxt  = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'b00;
            r_id    <= 2'b00;
            r_gnt   <= 4'b0000;
            r_hold  <= 8'd0;
            r_exp   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_id_nxt;
            r_gnt   <= w_gnt_nxt;
            r_hold  <= w_hold_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_id;
    assign busy    = |r_gnt;
    assign expired = r_exp;
endmodule
